bitstream_fetch_unit: RTL and testbench
=======================================

# bitstream_fetch_unit

Parametrised bitstream front end for the H.264 decoder. It fetches fixed-width words from the BitStream RAM into a bounded bit buffer and presents a left-aligned bit window to the syntax parser. The parser consumes a variable number of bits per cycle. Beyond the fixed 16-bit fetch path in the current decoder, it adds configurable word and window widths, buffer depth, start/end address bounds, restart (seek), byte alignment and end-of-stream detection.

## Interface
- DATA_W, 16, RAM word width in bits.
- ADDR_W, 17, RAM address width.
- DEPTH_WORDS, 4, buffer capacity in words; must be a power of 2 and ≥2.
- WIN_W, 16, window width in bits; WIN_W ≤ DATA_W*(DEPTH_WORDS-1).
- Derived: CAP = DATA_W*DEPTH_WORDS; CNT_W = $clog2(CAP+1); LEN_W = $clog2(WIN_W+1).
- Single clock; synchronous, active-high reset. These two facts are already decided.
- clk  in  1  Sole clock. All logic is rising-edge.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  Pulse. Flushes the buffer and begins fetching at start_addr.
- start_addr  in  ADDR_W  First word address. Sampled when start=1.
- end_addr  in  ADDR_W  Last word address, inclusive. Sampled when start=1.
- ram_ren  out  1  RAM read enable. Registered output.
- ram_addr  out  ADDR_W  RAM read address. Registered output.
- ram_rdata  in  DATA_W  RAM data, valid exactly 1 cycle after ram_ren.
- win_data  out  WIN_W  Next unconsumed bits, MSB first. Bit positions at or beyond bits_avail read as 0.
- win_valid  out  1  High when bits_avail ≥ WIN_W, or when fetch is done and bits_avail > 0.
- bits_avail  out  CNT_W  Number of unconsumed bits held in the buffer.
- consume  in  1  Consume consume_len bits this cycle.
- consume_len  in  LEN_W  Bits to consume, range 0..WIN_W.
- align  in  1  Consume up to the next byte boundary of the stream.
- busy  out  1  High in FETCH and DRAIN.
- eos  out  1  End of stream. Level output; cleared by start or reset.
- err  out  1  One-cycle pulse on an illegal request.

## Operation
- States:
  - IDLE → FETCH on start.
  - FETCH → DRAIN once a read has been issued for end_addr.
  - DRAIN → IDLE when no read is in flight and bits_avail = 0; eos is set on this transition.
  - start in any state → FETCH.
- Buffer: a CAP-bit left-aligned shift register plus bits_avail.
  - An arriving RAM word is written at bit offset bits_avail after any same-cycle consume.
  - Write and consume in the same cycle are both applied: bits_avail' = bits_avail − n + DATA_W.
- Fetch credit: ram_ren is asserted in cycle k+1 only if:
  - the state is FETCH, and
  - the next address ≤ end_addr, and
  - bits_avail(k) + DATA_W*(ram_ren(k) + rdata_pending(k) + 1) ≤ CAP.
  - This rule ignores same-cycle consume (conservative). Overflow is impossible.
  - ram_addr increments by 1 after each issued read.
- Consume:
  - n = consume_len, shifted out MSB-first.
  - consume_len = 0 is a no-op.
  - If consume_len > bits_avail: err pulses and the buffer is unchanged.
- Align:
  - A 3-bit counter tracks the stream bit position mod 8, cleared by start.
  - align consumes (8 − pos) mod 8 bits; pos = 0 is a no-op.
  - If that count exceeds bits_avail: err pulses and the buffer is unchanged.
  - align together with consume: align wins, consume is ignored, and err pulses.
- start mid-operation:
  - Clears the buffer, bits_avail, the position counter and eos.
  - A read in flight at the start cycle has its ram_rdata discarded.
  - ram_addr reloads.
- start with start_addr > end_addr: the block goes straight to DRAIN, then IDLE with eos=1, and issues no reads.

## Timing
- Reset values: ram_ren=0, ram_addr=0, win_data=0, win_valid=0, bits_avail=0, busy=0, eos=0, err=0, state IDLE.
- Every output is registered.
- start sampled at edge E0:
  - cycle 1: ram_ren=1 with ram_addr=start_addr.
  - cycle 2: ram_rdata valid.
  - cycle 3: bits_avail=DATA_W and win_data updated.
- Consume/align effects are visible on win_data and bits_avail in the cycle after they are sampled.
- err is high for the cycle after the offending request.
- Sustained rate: one word per cycle while the credit rule allows.

## Test plan
- Reset: assert reset for 2 cycles mid-stream → all outputs 0 next cycle and state IDLE.
- Fill (DATA_W=16, WIN_W=16):
  - Stimulus: start_addr=0x00010, end_addr=0x00013, RAM word at address a = 0xA000+a.
  - ram_addr sequence 0x10, 0x11, … with ram_ren deasserted after 0x13.
  - Cycle 3: win_data=0xA010, bits_avail=16.
  - bits_avail never exceeds 64.
- Consume then align, from a buffer holding 0xA010, 0xA011:
  - consume 3 bits → win_data=0x0085.
  - then align → 5 bits consumed, win_data=0x10A0.
  - then align again → no-op.
- Errors:
  - bits_avail=4, consume_len=5 → err=1 for one cycle, bits_avail stays 4.
  - align and consume in the same cycle → err=1, only align applied.
- Restart: start with start_addr=0x00100 while a read of 0x00012 is in flight → stale word discarded, first win_data=0x A100 (word at 0x100), pos counter cleared.
- EOS: consume the whole 4-word stream 16 bits per cycle → win_valid falls, busy falls, eos=1 after the last consume, and no ram_ren after 0x13.

Source files
------------

// File: rtl/bitstream_fetch_unit.sv
// Bitstream front end: fetches RAM words into a left-aligned bit buffer and
// presents an MSB-first window of unconsumed bits to the syntax parser.
//
// state | meaning
// IDLE  | no stream active; waiting for start
// FETCH | issuing reads while buffer credit allows
// DRAIN | last read issued; waiting for buffer to empty
module bitstream_fetch_unit #(
  parameter  int DATA_W      = 16,
  parameter  int ADDR_W      = 17,
  parameter  int DEPTH_WORDS = 4,
  parameter  int WIN_W       = 16,
  localparam int CAP         = DATA_W * DEPTH_WORDS,
  localparam int CNT_W       = $clog2(CAP + 1),
  localparam int LEN_W       = $clog2(WIN_W + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  output logic              ram_ren_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [WIN_W-1:0]  win_data_o,
  output logic              win_valid_o,
  output logic [CNT_W-1:0]  bits_avail_o,
  input  logic              consume_i,
  input  logic [LEN_W-1:0]  consume_len_i,
  input  logic              align_i,
  output logic              busy_o,
  output logic              eos_o,
  output logic              err_o
);

  localparam int EXT_W = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  logic               ram_ren_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [ADDR_W:0]    next_addr_q;  // one extra bit so end_addr at max never wraps
  logic [ADDR_W-1:0]  end_q;
  logic               pend_q;
  logic               eos_q;

  logic [CAP-1:0]     buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pos_q;
  logic [WIN_W-1:0]   win_q;
  logic               win_valid_q;
  logic               err_q;

  logic [2:0]         align_n;
  logic [CNT_W-1:0]   n;
  logic               req_err;
  logic [CNT_W-1:0]   cnt_after;
  logic [CAP-1:0]     buf_shift;
  logic [CAP-1:0]     word_ext;
  logic [1:0]         words_out;
  logic [EXT_W-1:0]   need;
  logic               credit_ok;
  logic               done_d;

  // (8 - pos) mod 8 in 3-bit arithmetic
  assign align_n   = 3'd0 - pos_q;

  // Credit counts buffered bits plus every word already requested, ignoring consume
  assign words_out = 2'(ram_ren_q) + 2'(pend_q) + 2'd1;
  assign need      = EXT_W'(cnt_q) + EXT_W'(words_out) * EXT_W'(DATA_W);
  assign credit_ok = (need <= EXT_W'(CAP));

  // Fetching is finished after this edge when no read is issued or landing
  assign done_d    = !start_i && (state_q != FETCH) && !ram_ren_q;

  // Decode consume/align into a shift amount and an error flag
  always_comb begin
    req_err = 1'b0;
    n       = '0;
    if (align_i) begin
      if (CNT_W'(align_n) <= cnt_q) n = CNT_W'(align_n);
      else                          req_err = 1'b1;
      if (consume_i) req_err = 1'b1;
    end else if (consume_i) begin
      if ((consume_len_i > LEN_W'(WIN_W)) || (CNT_W'(consume_len_i) > cnt_q)) req_err = 1'b1;
      else n = CNT_W'(consume_len_i);
    end
  end

  // Shift out consumed bits, then append any arriving word right after the remainder
  always_comb begin
    cnt_after = cnt_q - n;
    buf_shift = buf_q << n;
    word_ext  = {ram_rdata_i, {(CAP-DATA_W){1'b0}}};
    buf_d     = buf_shift;
    cnt_d     = cnt_after;
    if (start_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (pend_q) begin
      buf_d = buf_shift | (word_ext >> cnt_after);
      cnt_d = cnt_after + CNT_W'(DATA_W);
    end
  end

  // Sequencing FSM with registered RAM request, end-of-stream and in-flight tracking
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ram_ren_q   <= 1'b0;
      ram_addr_q  <= '0;
      next_addr_q <= '0;
      end_q       <= '0;
      pend_q      <= 1'b0;
      eos_q       <= 1'b0;
    end else begin
      pend_q <= ram_ren_q & ~start_i;
      if (start_i) begin
        end_q <= end_addr_i;
        eos_q <= 1'b0;
        if (start_addr_i <= end_addr_i) begin
          ram_ren_q   <= 1'b1;
          ram_addr_q  <= start_addr_i;
          next_addr_q <= {1'b0, start_addr_i} + 1'b1;
          state_q     <= (start_addr_i == end_addr_i) ? DRAIN : FETCH;
        end else begin
          ram_ren_q <= 1'b0;
          state_q   <= DRAIN;
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (credit_ok && (next_addr_q <= {1'b0, end_q})) begin
              ram_ren_q   <= 1'b1;
              ram_addr_q  <= next_addr_q[ADDR_W-1:0];
              next_addr_q <= next_addr_q + 1'b1;
              if (next_addr_q == {1'b0, end_q}) state_q <= DRAIN;
            end else begin
              ram_ren_q <= 1'b0;
            end
          end
          DRAIN: begin
            ram_ren_q <= 1'b0;
            if (!ram_ren_q && !pend_q && (cnt_q == '0)) begin
              state_q <= IDLE;
              eos_q   <= 1'b1;
            end
          end
          default: ram_ren_q <= 1'b0;
        endcase
      end
    end
  end

  // Bit buffer, stream position and registered window outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      pos_q       <= start_i ? 3'd0 : pos_q + n[2:0];
      win_q       <= buf_d[CAP-1 -: WIN_W];
      win_valid_q <= (cnt_d >= CNT_W'(WIN_W)) || (done_d && (cnt_d != '0));
      err_q       <= req_err & ~start_i;
    end
  end

  assign ram_ren_o    = ram_ren_q;
  assign ram_addr_o   = ram_addr_q;
  assign win_data_o   = win_q;
  assign win_valid_o  = win_valid_q;
  assign bits_avail_o = cnt_q;
  assign busy_o       = (state_q != IDLE);
  assign eos_o        = eos_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bitstream_fetch_unit.sv
// Directed bench for bitstream_fetch_unit with default parameters.
// RAM model returns 0xA000 + address one cycle after a read enable.
module tb_bitstream_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [16:0] start_addr;
  logic [16:0] end_addr;
  logic        ram_ren;
  logic [16:0] ram_addr;
  logic [15:0] ram_rdata;
  logic [15:0] win_data;
  logic        win_valid;
  logic [6:0]  bits_avail;
  logic        consume;
  logic [4:0]  consume_len;
  logic        align;
  logic        busy;
  logic        eos;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int max_bits = 0;

  always #5 clk = ~clk;

  bitstream_fetch_unit dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .start_addr_i (start_addr),
    .end_addr_i   (end_addr),
    .ram_ren_o    (ram_ren),
    .ram_addr_o   (ram_addr),
    .ram_rdata_i  (ram_rdata),
    .win_data_o   (win_data),
    .win_valid_o  (win_valid),
    .bits_avail_o (bits_avail),
    .consume_i    (consume),
    .consume_len_i(consume_len),
    .align_i      (align),
    .busy_o       (busy),
    .eos_o        (eos),
    .err_o        (err)
  );

  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= 16'hA000 + ram_addr[15:0];
  end

  always @(negedge clk) begin
    if (int'(bits_avail) > max_bits) max_bits = int'(bits_avail);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [16:0] sa, input logic [16:0] ea);
    start      = 1'b1;
    start_addr = sa;
    end_addr   = ea;
    next_cyc();
    start      = 1'b0;
  endtask

  task automatic wait_bits(input string tag, input int target);
    for (int k = 0; k < 20 && int'(bits_avail) != target; k++) next_cyc();
    check_val(tag, 32'(bits_avail), 32'(target));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    start_addr  = '0;
    end_addr    = '0;
    consume     = 1'b0;
    consume_len = '0;
    align       = 1'b0;
    ram_rdata   = '0;
    next_cyc();
    next_cyc();
    reset = 1'b0;
    check_val("rst_ren",   32'(ram_ren),    32'd0);
    check_val("rst_addr",  32'(ram_addr),   32'd0);
    check_val("rst_win",   32'(win_data),   32'd0);
    check_val("rst_bits",  32'(bits_avail), 32'd0);
    check_val("rst_busy",  32'(busy),       32'd0);
    check_val("rst_eos",   32'(eos),        32'd0);
    next_cyc();

    // Fill 0x10..0x13
    max_bits = 0;
    do_start(17'h10, 17'h13);
    check_val("fill_ren_c1",  32'(ram_ren),  32'd1);
    check_val("fill_addr_c1", 32'(ram_addr), 32'h10);
    check_val("fill_busy_c1", 32'(busy),     32'd1);
    next_cyc();
    check_val("fill_ren_c2",  32'(ram_ren),  32'd1);
    check_val("fill_addr_c2", 32'(ram_addr), 32'h11);
    next_cyc();
    check_val("fill_addr_c3", 32'(ram_addr), 32'h12);
    check_val("fill_win_c3",  32'(win_data), 32'hA010);
    check_val("fill_bits_c3", 32'(bits_avail), 32'd16);
    next_cyc();
    check_val("fill_ren_c4",  32'(ram_ren),  32'd1);
    check_val("fill_addr_c4", 32'(ram_addr), 32'h13);
    next_cyc();
    check_val("fill_ren_c5",  32'(ram_ren),  32'd0);
    check_val("fill_bits_c5", 32'(bits_avail), 32'd48);
    next_cyc();
    check_val("fill_ren_c6",  32'(ram_ren),  32'd0);
    check_val("fill_bits_c6", 32'(bits_avail), 32'd64);
    check_val("fill_valid",   32'(win_valid), 32'd1);
    next_cyc();
    check_val("fill_max_bits", 32'(max_bits), 32'd64);

    // EOS: consume the whole stream 16 bits per cycle
    consume     = 1'b1;
    consume_len = 5'd16;
    for (int i = 1; i < 4; i++) begin
      next_cyc();
      check_val("eos_win",  32'(win_data),   32'hA010 + 32'(i));
      check_val("eos_bits", 32'(bits_avail), 32'(64 - 16 * i));
      check_val("eos_ren",  32'(ram_ren),    32'd0);
    end
    next_cyc();
    consume = 1'b0;
    check_val("eos_bits0",  32'(bits_avail), 32'd0);
    check_val("eos_valid0", 32'(win_valid),  32'd0);
    check_val("eos_win0",   32'(win_data),   32'd0);
    next_cyc();
    check_val("eos_flag",   32'(eos),     32'd1);
    check_val("eos_busy",   32'(busy),    32'd0);
    check_val("eos_ren_end", 32'(ram_ren), 32'd0);

    // Consume then align on a two-word stream
    do_start(17'h10, 17'h11);
    check_val("ca_eos_clr", 32'(eos), 32'd0);
    wait_bits("ca_bits32", 32);
    check_val("ca_win0", 32'(win_data), 32'hA010);
    consume     = 1'b1;
    consume_len = 5'd3;
    next_cyc();
    consume = 1'b0;
    check_val("ca_cons3_win",  32'(win_data),   32'h0085);
    check_val("ca_cons3_bits", 32'(bits_avail), 32'd29);
    align = 1'b1;
    next_cyc();
    check_val("ca_align_win",  32'(win_data),   32'h10A0);
    check_val("ca_align_bits", 32'(bits_avail), 32'd24);
    check_val("ca_align_err",  32'(err),        32'd0);
    next_cyc();
    align = 1'b0;
    check_val("ca_noop_win",  32'(win_data),   32'h10A0);
    check_val("ca_noop_bits", 32'(bits_avail), 32'd24);

    // Errors on a one-word stream
    do_start(17'h10, 17'h10);
    wait_bits("er_bits16", 16);
    consume     = 1'b1;
    consume_len = 5'd12;
    next_cyc();
    check_val("er_bits4",   32'(bits_avail), 32'd4);
    check_val("er_valid4",  32'(win_valid),  32'd1);
    consume_len = 5'd5;
    next_cyc();
    consume = 1'b0;
    check_val("er_over_err",  32'(err),        32'd1);
    check_val("er_over_bits", 32'(bits_avail), 32'd4);
    next_cyc();
    check_val("er_pulse_end", 32'(err), 32'd0);
    align       = 1'b1;
    consume     = 1'b1;
    consume_len = 5'd2;
    next_cyc();
    align   = 1'b0;
    consume = 1'b0;
    check_val("er_both_err",  32'(err),        32'd1);
    check_val("er_both_bits", 32'(bits_avail), 32'd0);
    next_cyc();
    check_val("er_both_eos",  32'(eos), 32'd1);

    // Empty range: straight to DRAIN, then IDLE with eos, no reads
    do_start(17'h20, 17'h1F);
    check_val("empty_ren",  32'(ram_ren), 32'd0);
    check_val("empty_busy", 32'(busy),    32'd1);
    check_val("empty_eos0", 32'(eos),     32'd0);
    next_cyc();
    check_val("empty_eos1",  32'(eos),  32'd1);
    check_val("empty_busy0", 32'(busy), 32'd0);

    // Restart while reads are in flight
    do_start(17'h10, 17'h13);
    next_cyc();
    next_cyc();
    check_val("rs_bits16", 32'(bits_avail), 32'd16);
    consume     = 1'b1;
    consume_len = 5'd3;
    next_cyc();
    consume = 1'b0;
    check_val("rs_inflight", 32'(ram_ren), 32'd1);
    do_start(17'h100, 17'h103);
    check_val("rs_addr",  32'(ram_addr),   32'h100);
    check_val("rs_bits0", 32'(bits_avail), 32'd0);
    next_cyc();
    check_val("rs_stale", 32'(bits_avail), 32'd0);
    next_cyc();
    check_val("rs_win",   32'(win_data),   32'hA100);
    check_val("rs_bits",  32'(bits_avail), 32'd16);
    align = 1'b1;
    next_cyc();
    align = 1'b0;
    check_val("rs_pos_win", 32'(win_data), 32'hA100);
    check_val("rs_pos_err", 32'(err),      32'd0);

    // Reset mid-stream
    reset = 1'b1;
    next_cyc();
    next_cyc();
    reset = 1'b0;
    check_val("mr_ren",   32'(ram_ren),    32'd0);
    check_val("mr_addr",  32'(ram_addr),   32'd0);
    check_val("mr_win",   32'(win_data),   32'd0);
    check_val("mr_valid", 32'(win_valid),  32'd0);
    check_val("mr_bits",  32'(bits_avail), 32'd0);
    check_val("mr_busy",  32'(busy),       32'd0);
    check_val("mr_eos",   32'(eos),        32'd0);
    next_cyc();
    check_val("mr_idle_ren",  32'(ram_ren), 32'd0);
    check_val("mr_idle_busy", 32'(busy),    32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
